tetris_input: RTL

- Upstream conditioner for the tetris top level. Takes six raw, asynchronous, bouncing push-button levels and produces clean one-`clk`-cycle command pulses: `move_left`, `move_right`, `move_down`, `drop`, `rotate_right`, `rotate_left`.
- Each button is synchronised, debounced and edge-detected.
- Left/right/down additionally auto-repeat while held, so the game engine only ever sees single-cycle commands.

---
 rtl/tetris_input.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tetris_input.sv
// tetris_input: button conditioner for the tetris top level.
//
// Takes six raw, asynchronous, bouncing push-button levels and produces
// clean single-cycle command pulses. Each button goes through a two-flop
// synchroniser and a debounce counter. A registered pulse is produced on
// every accepted press. Left, right and down also auto-repeat while they
// are held.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   btn_*          raw button levels, 1 = pressed
//   move_left / move_right / move_down / drop / rotate_right / rotate_left
//                  one-cycle command pulses (registered)
//   held           debounced levels {rot_left, rot_right, drop, down, right, left}
module tetris_input #(
  parameter int DebounceCycles = 1000000,
  parameter int RepeatDelay    = 25000000,
  parameter int RepeatPeriod   = 8000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_drop,
  input  logic       btn_rot_right,
  input  logic       btn_rot_left,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       drop,
  output logic       rotate_right,
  output logic       rotate_left,
  output logic [5:0] held
);

  localparam int DW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int RMAX = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DCNT_LAST   = DW'(DebounceCycles - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(RepeatDelay - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(RepeatPeriod - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_PERIOD = 2'd2;

  logic [5:0] raw;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [5:0] stable;
  logic [5:0] accept;   // debounce counter expires on this edge: level flips
  logic [5:0] rise;
  logic [2:0] rep_hit;

  // Bit order matches the held output.
  assign raw = {btn_rot_left, btn_rot_right, btn_drop, btn_down, btn_right, btn_left};

  // Two-flop synchroniser; everything downstream reads sync2 only.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 6'b0;
      sync2 <= 6'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_deb
    logic [DW-1:0] dcnt;
    logic          level;

    assign stable[g] = level;
    assign accept[g] = (sync2[g] != level) && (dcnt == DCNT_LAST);
    assign rise[g]   = accept[g] & ~level;

    // Debounce: the synchronised level must differ from the accepted one
    // for DebounceCycles consecutive edges; any bounce back restarts it.
    always_ff @(posedge clk) begin
      if (reset) begin
        dcnt  <= {DW{1'b0}};
        level <= 1'b0;
      end else if (sync2[g] == level) begin
        dcnt <= {DW{1'b0}};
      end else if (dcnt == DCNT_LAST) begin
        level <= sync2[g];
        dcnt  <= {DW{1'b0}};
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rep
    logic [1:0]    state;
    logic [RW-1:0] rcnt;
    logic          conflict;
    logic          fall;
    logic          hit;

    // Left and right pressed together freeze each other's repeat.
    if (g < 2) begin : g_lr
      assign conflict = stable[0] & stable[1];
    end else begin : g_dn
      assign conflict = 1'b0;
    end

    assign fall       = accept[g] & stable[g];
    assign rep_hit[g] = hit;

    // Repeat pulse when the running count reaches the end of its phase;
    // never on the release edge or while frozen by a conflict.
    always_comb begin
      hit = 1'b0;
      if (stable[g] && !fall && !conflict) begin
        case (state)
          ST_DELAY:  hit = (rcnt == DELAY_LAST);
          ST_PERIOD: hit = (rcnt == PERIOD_LAST);
          default:   hit = 1'b0;
        endcase
      end else begin
        hit = 1'b0;
      end
    end

    // Repeat FSM: IDLE -> DELAY on press -> PERIOD after first repeat.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_IDLE;
        rcnt  <= {RW{1'b0}};
      end else if (fall || (!stable[g] && !rise[g])) begin
        state <= ST_IDLE;
        rcnt  <= {RW{1'b0}};
      end else if (rise[g] || conflict) begin
        state <= ST_DELAY;
        rcnt  <= {RW{1'b0}};
      end else if (hit) begin
        state <= ST_PERIOD;
        rcnt  <= {RW{1'b0}};
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

  // Registered command pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_left    <= 1'b0;
      move_right   <= 1'b0;
      move_down    <= 1'b0;
      drop         <= 1'b0;
      rotate_right <= 1'b0;
      rotate_left  <= 1'b0;
    end else begin
      move_left    <= rise[0] | rep_hit[0];
      move_right   <= rise[1] | rep_hit[1];
      move_down    <= rise[2] | rep_hit[2];
      drop         <= rise[3];
      rotate_right <= rise[4];
      rotate_left  <= rise[5];
    end
  end

  assign held = stable;

endmodule
